regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of write-back requesters, legal range 2..4.
REQ-002 Parameter AW, default 5: register address width, for 32 registers.
REQ-003 Parameter DW, default 32: register data width.
REQ-004 clk  input  1  the single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  when 1, no grants are issued.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_addr  input  NREQ*AW  per-requester destination register; slice i is bits [i*AW +: AW].
REQ-009 req_data  input  NREQ*DW  per-requester write data; slice i is bits [i*DW +: DW].
REQ-010 req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-011 rf_we  output  1  register-file write enable, drives RegWrite.
REQ-012 rf_waddr  output  AW  drives WriteRegister.
REQ-013 rf_wdata  output  DW  drives WriteData.
REQ-014 commit_cnt  output  16  count of writes presented to the register file; wraps.

Function
REQ-015 A transfer on requester i shall occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 req_ready shall be combinational from req_valid, hold and rr_ptr, with at most one bit set.
REQ-017 Grant order: scan from index rr_ptr upward, modulo NREQ, and grant the first valid requester; if hold=1 or no requester is valid, req_ready=0.
REQ-018 rr_ptr (internal, clog2(NREQ) bits) shall become (granted index + 1) mod NREQ on a transfer, and is otherwise unchanged.
REQ-019 Latency: a transfer in cycle N shall produce rf_we=1 in cycle N+1, with rf_waddr and rf_wdata equal to the accepted slice.
REQ-020 With no transfer in cycle N, rf_we=0 in cycle N+1, and rf_waddr/rf_wdata hold their previous values.
REQ-021 Requesters shall hold valid, addr and data stable until ready; the bench asserts this rule, and the block does not check it.
REQ-022 Back-to-back transfers are permitted every cycle; throughput is 1 write/cycle.
REQ-023 Fairness: a continuously valid requester shall be granted within NREQ cycles, excluding cycles with hold=1.
REQ-024 commit_cnt shall increment by 1 in each cycle in which rf_we transitions to 1 or stays at 1; 16'hFFFF wraps to 0.
REQ-025 If hold rises while a request is pending, no grant is issued; a write already registered still completes the next cycle.
REQ-026 Same-address requests from two requesters are serialized in grant order; the later-granted data persists.

Reset
REQ-027 On reset=1, asynchronously: rf_we=0, rf_waddr=0, rf_wdata=0, commit_cnt=0, rr_ptr=0.
REQ-028 During reset, req_ready=0 regardless of req_valid.
REQ-029 A transfer coincident with reset assertion is discarded; after deassertion, arbitration restarts at index 0.

Configuration
REQ-030 Macro RF_WB_ZERO_GUARD_EN defined: a transfer with addr==0 is accepted (ready given, rr_ptr advances), but rf_we stays 0 and commit_cnt does not increment.
REQ-031 Macro RF_WB_ZERO_GUARD_EN undefined: addr==0 writes are forwarded like any other address.

Structure
REQ-032 Package regfile_pkg shall hold the RF_AW=5, RF_DW=32 and RF_NREGS=32 constants and a typedef rf_wr_t {addr, data}.
REQ-033 Sub-module rr_arbiter (NREQ-wide, combinational grant plus pointer register) shall be instantiated once; the output register stage lives in the top module.

Verification
REQ-034 Reset then a single request: req_valid=3'b001, addr=5'd10, data=32'hDEAD_BEEF -> ready[0]=1 the same cycle; next cycle rf_we=1, rf_waddr=10, rf_wdata=32'hDEAD_BEEF; commit_cnt=1.
REQ-035 All three requesters valid for 6 cycles -> grant order 0,1,2,0,1,2; rf_we=1 for 6 consecutive cycles; commit_cnt=6.
REQ-036 hold=1 for 3 cycles with req_valid=3'b110 -> req_ready=0 and rf_we=0; after release, grant goes to 1, then to 2.
REQ-037 With RF_WB_ZERO_GUARD_EN defined, a request with addr=0, data=32'h1 -> ready=1, rf_we stays 0, commit_cnt unchanged; the same stimulus without the macro -> rf_we=1, rf_waddr=0.
REQ-038 Reset asserted mid-stream while requesters 1 and 2 are valid -> outputs are 0 immediately; after release the first grant goes to requester 1.
REQ-039 Preload commit_cnt to 16'hFFFE via a 65534-write run, then 2 writes -> commit_cnt=16'h0000.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file constants and the write-record type used
//               by the write-back arbiter and its round-robin sub-block.
// Contents    : RF_AW    - register address width (32 registers)
//               RF_DW    - register data width
//               RF_NREGS - number of architectural registers
//               rf_wr_t  - one register-file write {addr, data}
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : NREQ-wide round-robin arbiter. The grant is combinational from
//               the valid vector, hold, reset and the rotating pointer; the
//               pointer moves to one past the granted index on every grant.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (pointer -> 0,
//                          grant forced to zero while asserted)
//               i_hold   - suppresses all grants
//               i_valid  - per-requester request
//               o_grant  - one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hold,
  input  logic [NREQ-1:0] i_valid,
  output logic [NREQ-1:0] o_grant
);

  localparam int c_PW = $clog2(NREQ);

  logic [c_PW-1:0] r_ptr;
  logic [c_PW-1:0] w_gnt_idx;
  logic [c_PW-1:0] w_next_ptr;
  logic [NREQ-1:0] w_grant;
  logic            w_found;

  // Scan offsets 0..NREQ-1 from the pointer; the first valid index wins.
  // The inner loop compares against every physical index so that no
  // out-of-range dynamic bit select is ever formed for non-power-of-2 NREQ.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    if (!i_hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_found && (i == ((int'(r_ptr) + k) % NREQ)) && i_valid[i]) begin
            w_found    = 1'b1;
            w_grant[i] = 1'b1;
            w_gnt_idx  = c_PW'(i);
          end
        end
      end
    end
  end

  assign w_next_ptr = (w_gnt_idx == c_PW'(NREQ - 1)) ? '0 : (w_gnt_idx + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign o_grant = w_grant;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter in front of a register file.
//               One requester is accepted per cycle; the accepted address and
//               data are registered and presented to the register file one
//               cycle later together with a write enable. A 16-bit wrapping
//               counter tracks writes presented to the register file.
// Ports       : clk        - clock
//               reset      - asynchronous active-high reset
//               hold       - blocks all grants while high
//               req_valid  - [NREQ]    per-requester write request
//               req_addr   - [NREQ*AW] slice i at [i*AW +: AW]
//               req_data   - [NREQ*DW] slice i at [i*DW +: DW]
//               req_ready  - [NREQ]    one-hot or zero grant
//               rf_we      - register-file write enable
//               rf_waddr   - register-file write address
//               rf_wdata   - register-file write data
//               commit_cnt - writes presented to the register file (wraps)
// Macro       : RF_WB_ZERO_GUARD_EN - when defined, a transfer to register 0
//               is accepted but produces no register-file write and no count.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [15:0]        commit_cnt
);

  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic            w_wr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [15:0]     r_cnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (reset),
    .i_hold  (hold),
    .i_valid (req_valid),
    .o_grant (w_grant)
  );

  // Grant is one-hot, so a simple OR-style select picks the accepted slice.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_xfer = |w_grant;

`ifdef RF_WB_ZERO_GUARD_EN
  // Register 0 is hard-wired: accept the transfer but drop the write.
  assign w_wr = w_xfer && (w_sel_addr != '0);
`else
  assign w_wr = w_xfer;
`endif

  // Address/data only load on a real write so they hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_cnt   <= r_cnt + 16'd1;
      end
    end
  end

  assign req_ready  = w_grant;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign commit_cnt = r_cnt;

endmodule : regfile_wb_arbiter
`default_nettype wire
